axi_data_write_channel: RTL and testbench
=========================================

Name: axi_data_write_channel

Overview:
- AXI4 write-data (W) channel master for the DDR FIFO write path.
- Sits beside the write-address stage and consumes its one-cycle `start_single_burst_write` pulse.
- Per pulse, pops exactly C_M_AXI_BURST_LEN words from the ingress FIFO (standard FIFO, 1-cycle read latency) and drives them as one W burst with WLAST.
- A 2-entry output buffer absorbs WREADY backpressure and sustains 1 beat/cycle.

Parameters:
- C_M_AXI_DATA_WIDTH, 64: W data width in bits; must be a power of 2, at least 8.
- C_M_AXI_BURST_LEN, 16: beats per burst, range 1..256.
- CNT_W, clogb2(C_M_AXI_BURST_LEN)+1: width of the beat counters (derived, not user-set).

Ports:
- M_AXI_ACLK, in, 1: single clock.
- M_AXI_ARESET, in, 1: reset, asynchronous, active-high.
- start_single_burst_write, in, 1: one-cycle pulse; begin one burst.
- fifo_rd_en, out, 1: ingress FIFO pop; data is valid on fifo_dout one cycle later.
- fifo_dout, in, C_M_AXI_DATA_WIDTH: ingress FIFO read data.
- fifo_empty, in, 1: ingress FIFO empty.
- M_AXI_WDATA, out, C_M_AXI_DATA_WIDTH: write data.
- M_AXI_WSTRB, out, C_M_AXI_DATA_WIDTH/8: byte strobes.
- M_AXI_WLAST, out, 1: last beat of the burst.
- M_AXI_WVALID, out, 1: write data valid.
- M_AXI_WREADY, in, 1: slave ready.
- burst_write_done, out, 1: one-cycle pulse after the last W handshake.
- start_overrun, out, 1: sticky flag; a start arrived while busy.

Behaviour:
- Reset is asynchronous, active-high. On reset: state=IDLE; fifo_rd_en=0; M_AXI_WVALID=0; M_AXI_WLAST=0; M_AXI_WDATA=0; burst_write_done=0; start_overrun=0; counters=0; buffer emptied.
- Reset mid-burst aborts the burst. Words already popped are discarded, and recovery is left to system reset. After reset release nothing is driven until a new start pulse.
- M_AXI_WSTRB is tied all-ones.
- State IDLE:
  - On start_single_burst_write=1, clear rd_cnt and w_cnt and go to BURST.
  - A start that arrives in BURST is ignored and sets start_overrun=1. start_overrun clears only on reset.
- Read issue in BURST:
  - fifo_rd_en=1 when rd_cnt<C_M_AXI_BURST_LEN, fifo_empty=0, and (buf_count + inflight − pop_this_cycle) < 2.
  - inflight is a 1-bit register equal to the previous cycle's fifo_rd_en.
  - rd_cnt increments on each fifo_rd_en.
  - fifo_rd_en is registered-decision logic. It must never be asserted when fifo_empty=1 in the same cycle, and never more than BURST_LEN times per burst.
- Buffer:
  - When inflight=1, fifo_dout is written into the 2-entry buffer.
  - M_AXI_WVALID=1 whenever the buffer is non-empty; M_AXI_WDATA is the head entry.
  - A pop occurs on M_AXI_WVALID && M_AXI_WREADY.
  - Push and pop in the same cycle: count is unchanged and order is preserved.
  - The buffer never overflows; this is guaranteed by the credit rule above.
- WLAST and completion:
  - w_cnt increments on each W handshake.
  - M_AXI_WLAST = M_AXI_WVALID && (w_cnt == C_M_AXI_BURST_LEN−1). For BURST_LEN=1, WLAST is asserted with the first beat.
  - On the handshake with WLAST=1: burst_write_done pulses 1 in the next cycle and the state returns to IDLE that same cycle.
  - A start pulse coincident with the done pulse is accepted, so back-to-back bursts work.
- AXI rules:
  - WVALID never drops before a handshake.
  - WDATA and WLAST are stable while WVALID=1 && WREADY=0.
  - WVALID does not depend combinationally on WREADY.
- Latency, with start at cycle T, FIFO never empty and WREADY=1:
  - fifo_rd_en high for cycles T+1 .. T+BURST_LEN.
  - WVALID high for cycles T+2 .. T+BURST_LEN+1, with WLAST at T+BURST_LEN+1.
  - burst_write_done at T+BURST_LEN+2.
- FIFO empty mid-burst: stop issuing reads and let WVALID drain. Resume when fifo_empty=0; the beat count is preserved and no beat is duplicated.
- Widths: counters are CNT_W bits, so no wrap occurs at BURST_LEN=256.

Decomposition:
- Shared config header: C_M_AXI_DATA_WIDTH, C_M_AXI_BURST_LEN, the clogb2 function, and the state encoding localparams IDLE=1'b0, BURST=1'b1.
- Sub-module wdata_skid_buf: 2-entry FIFO with push/pop/count/head outputs, parameterised by width.
- The top level holds the FSM, the counters and the credit logic.

Test Plan:
- BURST_LEN=16, FIFO holds 0x0..0xF, WREADY=1, one start pulse -> 16 contiguous beats with WDATA 0..15, WLAST only on 0xF, done pulse exactly 18 cycles after start, exactly 16 fifo_rd_en.
- Same burst, WREADY toggling 1,0,0,1 repeating -> data order 0..15 intact, WDATA and WLAST stable during every stall, buffer never exceeds 2 entries.
- fifo_empty forced to 1 for 5 cycles after the 6th pop -> WVALID drops after beat 5, resumes with beat 6, total beats 16, no fifo_rd_en while empty.
- Start pulse at cycle T+4 mid-burst -> ignored, start_overrun=1 and sticky, still exactly 16 beats.
- Start pulse coincident with burst_write_done -> second burst begins; 32 beats total, two WLASTs, two done pulses.
- Reset asserted asynchronously at beat 7 -> WVALID, WLAST, fifo_rd_en and done all 0 immediately; no activity after release until a new start pulse; BURST_LEN=1 rerun gives WLAST on the single beat.

Source files
------------

// File: rtl/axi_data_write_channel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_data_write_channel_pkg
// Brief    : Shared defaults, beat-counter sizing helper and FSM encoding for
//            the AXI4 W-channel master.
// Revision : 1.0
// ============================================================================
package axi_data_write_channel_pkg;

    localparam int DEFAULT_DATA_WIDTH = 64;
    localparam int DEFAULT_BURST_LEN  = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // ceil(log2(value)); returns 0 for value <= 1
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_data_write_channel_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : wdata_skid_buf
// Brief    : Two-entry in-order FIFO holding W beats while WREADY is low.
// Revision : 1.0
// ============================================================================
module wdata_skid_buf #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] r_mem0;
    logic [WIDTH-1:0] r_mem1;
    logic [1:0]       r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem0  <= '0;
            r_mem1  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (r_count == 2'd0) r_mem0 <= din;
                    else                 r_mem1 <= din;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_mem0  <= r_mem1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Count unchanged; the new word lands behind whatever remains.
                    if (r_count == 2'd2) begin
                        r_mem0 <= r_mem1;
                        r_mem1 <= din;
                    end else begin
                        r_mem0 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign count = r_count;
    assign head  = r_mem0;

endmodule
`default_nettype wire

// File: rtl/axi_data_write_channel.sv
`default_nettype none
// ============================================================================
// Module   : axi_data_write_channel
// Brief    : AXI4 W-channel master; pops one burst of words from the ingress
//            FIFO per start pulse and drives them with WLAST and backpressure.
// Revision : 1.0
// ============================================================================
module axi_data_write_channel
    import axi_data_write_channel_pkg::*;
#(
    parameter int C_M_AXI_DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int C_M_AXI_BURST_LEN  = DEFAULT_BURST_LEN
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESET,
    input  logic                            start_single_burst_write,
    output logic                            fifo_rd_en,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   fifo_dout,
    input  logic                            fifo_empty,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WLAST,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    output logic                            burst_write_done,
    output logic                            start_overrun
);

    localparam int CNT_W = clogb2(C_M_AXI_BURST_LEN) + 1;
    localparam logic [CNT_W-1:0] C_LEN  = CNT_W'(C_M_AXI_BURST_LEN);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(C_M_AXI_BURST_LEN - 1);

    state_t                          r_state;
    logic [CNT_W-1:0]                r_rd_cnt;
    logic [CNT_W-1:0]                r_w_cnt;
    logic                            r_inflight;
    logic                            r_done;
    logic                            r_overrun;

    logic [1:0]                      w_buf_count;
    logic [C_M_AXI_DATA_WIDTH-1:0]   w_buf_head;
    logic                            w_buf_empty;
    logic                            w_wvalid;
    logic                            w_wlast;
    logic                            w_handshake;
    logic                            w_buf_push;
    logic                            w_buf_pop;
    logic [2:0]                      w_occ;
    logic                            w_rd_en;

    // A word returning from the FIFO is presented straight away when the buffer
    // is empty, which is what gives the two-cycle start-to-WVALID latency.
    assign w_buf_empty = (w_buf_count == 2'd0);
    assign w_wvalid    = !w_buf_empty || r_inflight;
    assign w_wlast     = w_wvalid && (r_w_cnt == C_LAST);
    assign w_handshake = w_wvalid && M_AXI_WREADY;
    assign w_buf_pop   = !w_buf_empty && M_AXI_WREADY;
    assign w_buf_push  = r_inflight && !(w_buf_empty && M_AXI_WREADY);

    // Credit: buffered + returning words, less the one leaving now, must leave room.
    assign w_occ   = {1'b0, w_buf_count} + {2'b00, r_inflight} - {2'b00, w_handshake};
    assign w_rd_en = (r_state == BURST) && (r_rd_cnt < C_LEN) && !fifo_empty
                     && (w_occ < 3'd2);

    wdata_skid_buf #(
        .WIDTH (C_M_AXI_DATA_WIDTH)
    ) u_skid_buf (
        .clk   (M_AXI_ACLK),
        .rst   (M_AXI_ARESET),
        .push  (w_buf_push),
        .din   (fifo_dout),
        .pop   (w_buf_pop),
        .count (w_buf_count),
        .head  (w_buf_head)
    );

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            r_state    <= IDLE;
            r_rd_cnt   <= '0;
            r_w_cnt    <= '0;
            r_inflight <= 1'b0;
            r_done     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            r_done     <= 1'b0;
            if (w_rd_en)     r_rd_cnt <= r_rd_cnt + CNT_W'(1);
            if (w_handshake) r_w_cnt  <= r_w_cnt + CNT_W'(1);
            case (r_state)
                IDLE: begin
                    if (start_single_burst_write) begin
                        r_rd_cnt <= '0;
                        r_w_cnt  <= '0;
                        r_state  <= BURST;
                    end
                end
                BURST: begin
                    if (start_single_burst_write) r_overrun <= 1'b1;
                    if (w_handshake && w_wlast) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign fifo_rd_en       = w_rd_en;
    assign M_AXI_WVALID     = w_wvalid;
    assign M_AXI_WLAST      = w_wlast;
    assign M_AXI_WDATA      = !w_buf_empty ? w_buf_head :
                              (r_inflight ? fifo_dout : '0);
    assign M_AXI_WSTRB      = '1;
    assign burst_write_done = r_done;
    assign start_overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_axi_data_write_channel.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_data_write_channel
// Brief    : Directed self-checking bench for the AXI4 W-channel master.
// Revision : 1.0
// ============================================================================
module tb_axi_data_write_channel;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        fifo_rd_en;
    logic [63:0] fifo_dout = 64'd0;
    logic        force_empty = 1'b0;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready = 1'b1;
    logic        done;
    logic        overrun;

    logic        start1 = 1'b0;
    logic        rd_en1;
    logic [63:0] dout1 = 64'hA5;
    logic        empty1 = 1'b0;
    logic [63:0] wdata1;
    logic [7:0]  wstrb1;
    logic        wlast1;
    logic        wvalid1;
    logic        wready1 = 1'b1;
    logic        done1;
    logic        overrun1;

    int n_checks = 0;
    int n_errors = 0;
    int ncyc = 0;
    logic [63:0] rd_ptr = 64'd0;
    logic        wr_mode = 1'b0;

    // Monitor bookkeeping
    logic [63:0] exp_data = 64'd0;
    int beat_in_burst = 0;
    int rd_total = 0;
    int beats_total = 0;
    int lasts_total = 0;
    int dones_total = 0;
    int occ_base = 0;
    logic        stall_prev = 1'b0;
    logic [63:0] stall_data = 64'd0;
    logic        stall_last = 1'b0;

    axi_data_write_channel #(
        .C_M_AXI_DATA_WIDTH (64),
        .C_M_AXI_BURST_LEN  (16)
    ) dut (
        .M_AXI_ACLK               (clk),
        .M_AXI_ARESET             (rst),
        .start_single_burst_write (start),
        .fifo_rd_en               (fifo_rd_en),
        .fifo_dout                (fifo_dout),
        .fifo_empty               (force_empty),
        .M_AXI_WDATA              (wdata),
        .M_AXI_WSTRB              (wstrb),
        .M_AXI_WLAST              (wlast),
        .M_AXI_WVALID             (wvalid),
        .M_AXI_WREADY             (wready),
        .burst_write_done         (done),
        .start_overrun            (overrun)
    );

    axi_data_write_channel #(
        .C_M_AXI_DATA_WIDTH (64),
        .C_M_AXI_BURST_LEN  (1)
    ) dut1 (
        .M_AXI_ACLK               (clk),
        .M_AXI_ARESET             (rst),
        .start_single_burst_write (start1),
        .fifo_rd_en               (rd_en1),
        .fifo_dout                (dout1),
        .fifo_empty               (empty1),
        .M_AXI_WDATA              (wdata1),
        .M_AXI_WSTRB              (wstrb1),
        .M_AXI_WLAST              (wlast1),
        .M_AXI_WVALID             (wvalid1),
        .M_AXI_WREADY             (wready1),
        .burst_write_done         (done1),
        .start_overrun            (overrun1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ncyc <= ncyc + 1;

    // Ingress FIFO model: word value equals its pop index, one-cycle read latency.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_dout <= rd_ptr;
            rd_ptr    <= rd_ptr + 64'd1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, ncyc);
        end
    endtask

    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            if (wr_mode) begin
                wready = (ph == 0) || (ph == 3);
                ph = (ph + 1) % 4;
            end else begin
                wready = 1'b1;
                ph = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            exp_data      = rd_ptr;
            beat_in_burst = 0;
            stall_prev    = 1'b0;
            occ_base      = rd_total - beats_total;
        end else begin
            if (force_empty) chk("rd_while_empty", 64'(fifo_rd_en), 64'd0);
            chk("occupancy_le2", 64'((rd_total - beats_total - occ_base) <= 2), 64'd1);
            if (stall_prev) begin
                chk("stall_wvalid", 64'(wvalid), 64'd1);
                chk("stall_wdata", wdata, stall_data);
                chk("stall_wlast", 64'(wlast), 64'(stall_last));
            end
            if (wvalid) begin
                chk("wdata_order", wdata, exp_data);
                chk("wlast_pos", 64'(wlast), 64'(beat_in_burst == 15));
            end
            if (fifo_rd_en) rd_total++;
            if (done) dones_total++;
            if (wvalid && wready) begin
                beats_total++;
                exp_data = exp_data + 64'd1;
                if (wlast) begin
                    lasts_total++;
                    beat_in_burst = 0;
                end else begin
                    beat_in_burst++;
                end
            end
            stall_prev = wvalid && !wready;
            stall_data = wdata;
            stall_last = wlast;
        end
    end

    task automatic start_pulse(output int t);
        @(posedge clk);
        #1 start = 1'b1;
        @(negedge clk);
        t = ncyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int c);
        int k;
        k = 0;
        c = -1;
        while (k < bound) begin
            @(negedge clk);
            if (done) begin
                c = ncyc;
                break;
            end
            k++;
        end
        if (c < 0) chk("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int t0, dc, n, gap, act;
        int b_beats, b_lasts, b_rd, b_dones;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wvalid", 64'(wvalid), 64'd0);
        chk("rst_wlast", 64'(wlast), 64'd0);
        chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        chk("rst_wdata", wdata, 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("wstrb_ones", 64'(wstrb), 64'hFF);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single burst, WREADY held high
        b_beats = beats_total; b_lasts = lasts_total; b_rd = rd_total; b_dones = dones_total;
        start_pulse(t0);
        @(negedge clk);
        chk("t1_rd_en_T1", 64'(fifo_rd_en), 64'd1);
        chk("t1_wvalid_T1", 64'(wvalid), 64'd0);
        @(negedge clk);
        chk("t1_wvalid_T2", 64'(wvalid), 64'd1);
        wait_done(60, dc);
        chk("t1_done_latency", 64'(dc - t0), 64'd18);
        @(posedge clk); #1;
        chk("t1_beats", 64'(beats_total - b_beats), 64'd16);
        chk("t1_lasts", 64'(lasts_total - b_lasts), 64'd1);
        chk("t1_rd_count", 64'(rd_total - b_rd), 64'd16);
        chk("t1_dones", 64'(dones_total - b_dones), 64'd1);

        // WREADY pattern 1,0,0,1
        wr_mode = 1'b1;
        b_beats = beats_total; b_lasts = lasts_total; b_rd = rd_total;
        start_pulse(t0);
        wait_done(200, dc);
        @(posedge clk); #1;
        wr_mode = 1'b0;
        chk("t2_beats", 64'(beats_total - b_beats), 64'd16);
        chk("t2_lasts", 64'(lasts_total - b_lasts), 64'd1);
        chk("t2_rd_count", 64'(rd_total - b_rd), 64'd16);

        // FIFO empty for 5 cycles after the 6th pop
        repeat (2) @(posedge clk);
        #1;
        b_beats = beats_total; b_rd = rd_total;
        start_pulse(t0);
        n = 0;
        for (int k = 0; k < 40 && n < 6; k++) begin
            @(negedge clk);
            if (fifo_rd_en) n++;
        end
        chk("t3_six_pops", 64'(n), 64'd6);
        @(posedge clk);
        #1 force_empty = 1'b1;
        gap = 0;
        repeat (5) begin
            @(negedge clk);
            if (!wvalid) gap++;
        end
        @(posedge clk);
        #1 force_empty = 1'b0;
        chk("t3_wvalid_gap", 64'(gap), 64'd4);
        wait_done(80, dc);
        @(posedge clk); #1;
        chk("t3_beats", 64'(beats_total - b_beats), 64'd16);
        chk("t3_rd_count", 64'(rd_total - b_rd), 64'd16);

        // Back-to-back: second start coincides with the first done pulse
        repeat (2) @(posedge clk);
        #1;
        b_beats = beats_total; b_lasts = lasts_total; b_rd = rd_total; b_dones = dones_total;
        start_pulse(t0);
        repeat (17) @(posedge clk);
        #1 start = 1'b1;
        @(negedge clk);
        chk("t5_done_coincident", 64'(done), 64'd1);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(60, dc);
        chk("t5_second_done_latency", 64'(dc - t0), 64'd36);
        @(posedge clk); #1;
        chk("t5_beats", 64'(beats_total - b_beats), 64'd32);
        chk("t5_lasts", 64'(lasts_total - b_lasts), 64'd2);
        chk("t5_dones", 64'(dones_total - b_dones), 64'd2);
        chk("t5_rd_count", 64'(rd_total - b_rd), 64'd32);
        chk("t5_no_overrun", 64'(overrun), 64'd0);

        // Start mid-burst is ignored and flagged
        repeat (2) @(posedge clk);
        #1;
        b_beats = beats_total; b_rd = rd_total;
        start_pulse(t0);
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("t4_overrun_set", 64'(overrun), 64'd1);
        wait_done(60, dc);
        chk("t4_done_latency", 64'(dc - t0), 64'd18);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_beats", 64'(beats_total - b_beats), 64'd16);
        chk("t4_rd_count", 64'(rd_total - b_rd), 64'd16);
        chk("t4_overrun_sticky", 64'(overrun), 64'd1);

        // Asynchronous reset while beat 7 is on the bus
        start_pulse(t0);
        n = 0;
        for (int k = 0; k < 40 && n < 7; k++) begin
            @(negedge clk);
            if (wvalid && wready) n++;
        end
        chk("t6_seven_beats", 64'(n), 64'd7);
        @(negedge clk);
        chk("t6_beat7_valid", 64'(wvalid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_wvalid", 64'(wvalid), 64'd0);
        chk("t6_async_wlast", 64'(wlast), 64'd0);
        chk("t6_async_rd_en", 64'(fifo_rd_en), 64'd0);
        chk("t6_async_done", 64'(done), 64'd0);
        chk("t6_async_wdata", wdata, 64'd0);
        chk("t6_async_overrun", 64'(overrun), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        act = 0;
        repeat (10) begin
            @(negedge clk);
            if (fifo_rd_en || wvalid || done) act++;
        end
        chk("t6_quiet_after_reset", 64'(act), 64'd0);
        @(posedge clk); #1;
        b_beats = beats_total; b_rd = rd_total;
        start_pulse(t0);
        wait_done(60, dc);
        chk("t6_rerun_latency", 64'(dc - t0), 64'd18);
        @(posedge clk); #1;
        chk("t6_rerun_beats", 64'(beats_total - b_beats), 64'd16);
        chk("t6_rerun_rd_count", 64'(rd_total - b_rd), 64'd16);

        // BURST_LEN = 1 instance
        @(posedge clk);
        #1 start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        @(negedge clk);
        chk("len1_rd_en", 64'(rd_en1), 64'd1);
        chk("len1_wvalid_early", 64'(wvalid1), 64'd0);
        @(negedge clk);
        chk("len1_wvalid", 64'(wvalid1), 64'd1);
        chk("len1_wlast", 64'(wlast1), 64'd1);
        chk("len1_wdata", wdata1, 64'hA5);
        chk("len1_rd_en_once", 64'(rd_en1), 64'd0);
        @(negedge clk);
        chk("len1_done", 64'(done1), 64'd1);
        chk("len1_wvalid_after", 64'(wvalid1), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
